// File: rtl/mvu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mvu_sequencer                                                              |
// | Job-driven phase counter, CAM read strobe and round-valid pipeline for MVU |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mvu_sequencer #(
  parameter int         FIND_LEN    = 64,
  parameter int         ROUND_START = 4,
  parameter int         ROUND_LEN   = 64,
  parameter int         ROUND_LAT   = 1,
  parameter int         GAP_LEN     = 2,
  parameter logic [7:0] IDLE_CNT    = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic [7:0] start_passes,
  input  logic       abort,
  output logic [7:0] MVU_counter,
  output logic       cam_rd_en,
  output logic [5:0] cam_rd_addr,
  output logic       round_valid,
  output logic [7:0] pass_idx,
  output logic       busy,
  output logic       done,
  output logic       aborted
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_GAP  = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  localparam logic [7:0] c_RUN_LAST    = 8'(ROUND_START + ROUND_LEN - 1);
  localparam logic [7:0] c_FIND_LEN    = 8'(FIND_LEN);
  localparam logic [7:0] c_ROUND_START = 8'(ROUND_START);
  localparam logic [7:0] c_GAP_LAST    = 8'(GAP_LEN - 1);

  logic [1:0]           state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [7:0]           pass_idx_q, pass_idx_d;
  logic [7:0]           passes_q, passes_d;
  logic [7:0]           gap_q, gap_d;
  logic [ROUND_LAT-1:0] pipe_q, pipe_d;
  logic                 done_q, done_d;
  logic                 aborted_q, aborted_d;
  logic                 armed_q;

  logic                 accept;
  logic                 round_win;
  logic [ROUND_LAT-1:0] pipe_shift;

  // Newest window sample enters at bit 0; round_valid taps the oldest bit.
  generate
    if (ROUND_LAT == 1) begin : g_lat_one
      assign pipe_shift = round_win;
    end else begin : g_lat_multi
      assign pipe_shift = {pipe_q[ROUND_LAT-2:0], round_win};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= c_IDLE;
      cnt_q      <= IDLE_CNT;
      pass_idx_q <= '0;
      passes_q   <= '0;
      gap_q      <= '0;
      pipe_q     <= '0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pass_idx_q <= pass_idx_d;
      passes_q   <= passes_d;
      gap_q      <= gap_d;
      pipe_q     <= pipe_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      armed_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pass_idx_d = pass_idx_q;
    passes_d   = passes_q;
    gap_d      = gap_q;
    pipe_d     = pipe_shift;
    aborted_d  = 1'b0;
    case (state_q)
      c_IDLE: begin
        if (accept) begin
          passes_d   = start_passes;
          pass_idx_d = '0;
          if (start_passes != 8'd0) begin
            state_d = c_RUN;
            cnt_d   = '0;
          end else begin
            state_d = c_DONE;
            cnt_d   = IDLE_CNT;
          end
        end
      end
      c_RUN: begin
        if (abort) begin
          state_d   = c_IDLE;
          cnt_d     = IDLE_CNT;
          pipe_d    = '0;
          aborted_d = 1'b1;
        end else if (cnt_q == c_RUN_LAST) begin
          cnt_d   = IDLE_CNT;
          gap_d   = '0;
          state_d = (pass_idx_q == passes_q - 8'd1) ? c_DONE : c_GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      c_GAP: begin
        if (abort) begin
          state_d   = c_IDLE;
          cnt_d     = IDLE_CNT;
          pipe_d    = '0;
          aborted_d = 1'b1;
        end else if (gap_q == c_GAP_LAST) begin
          state_d    = c_RUN;
          cnt_d      = '0;
          gap_d      = '0;
          pass_idx_d = pass_idx_q + 8'd1;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      c_DONE: begin
        state_d = c_IDLE;
        cnt_d   = IDLE_CNT;
      end
      default: begin
        state_d = c_IDLE;
        cnt_d   = IDLE_CNT;
      end
    endcase
    done_d = (state_d == c_DONE);
  end

  // armed_q holds start_ready low until the first edge after reset release.
  always_comb begin
    start_ready = armed_q && (state_q == c_IDLE) && (pipe_q == '0);
    accept      = start_valid && start_ready;
    cam_rd_en   = (state_q == c_RUN) && (cnt_q < c_FIND_LEN);
    cam_rd_addr = cam_rd_en ? cnt_q[5:0] : 6'd0;
    round_win   = (state_q == c_RUN) && (cnt_q >= c_ROUND_START) && (cnt_q <= c_RUN_LAST);
    busy        = (state_q != c_IDLE) || (pipe_q != '0);
  end

  assign MVU_counter = cnt_q;
  assign pass_idx    = pass_idx_q;
  assign round_valid = pipe_q[ROUND_LAT-1];
  assign done        = done_q;
  assign aborted     = aborted_q;

endmodule
`default_nettype wire

// File: tb/tb_mvu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mvu_sequencer                                                           |
// | Directed bench: default instance plus a ROUND_LAT=3 instance on same pins  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mvu_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_valid = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] start_passes = 8'd0;

  logic       start_ready, cam_rd_en, round_valid, busy, done, aborted;
  logic [7:0] MVU_counter, pass_idx;
  logic [5:0] cam_rd_addr;

  logic       start_ready_3, cam_rd_en_3, round_valid_3, busy_3, done_3, aborted_3;
  logic [7:0] MVU_counter_3, pass_idx_3;
  logic [5:0] cam_rd_addr_3;

  int checks = 0;
  int failures = 0;
  int rv_cnt = 0, rv3_cnt = 0, done_cnt = 0, abort_cnt = 0;
  int rvb, rvb3, db, ab, cyc;
  int obs_ptr = 0;
  logic [5:0] cam_obs[$];
  logic [5:0] cam_exp[$];

  always #5 clk = ~clk;

  mvu_sequencer dut (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
    .start_passes(start_passes), .abort(abort), .MVU_counter(MVU_counter),
    .cam_rd_en(cam_rd_en), .cam_rd_addr(cam_rd_addr), .round_valid(round_valid),
    .pass_idx(pass_idx), .busy(busy), .done(done), .aborted(aborted)
  );

  mvu_sequencer #(.ROUND_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready_3),
    .start_passes(start_passes), .abort(abort), .MVU_counter(MVU_counter_3),
    .cam_rd_en(cam_rd_en_3), .cam_rd_addr(cam_rd_addr_3), .round_valid(round_valid_3),
    .pass_idx(pass_idx_3), .busy(busy_3), .done(done_3), .aborted(aborted_3)
  );

  // Observation only: record CAM reads and pulse counts mid-cycle.
  always @(negedge clk) begin
    if (cam_rd_en) cam_obs.push_back(cam_rd_addr);
    if (round_valid) rv_cnt++;
    if (round_valid_3) rv3_cnt++;
    if (done) done_cnt++;
    if (aborted) abort_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_reads(input int n);
    for (int i = 0; i < n; i++) cam_exp.push_back(6'(i % 64));
  endtask

  task automatic sb_drain(input string tag, input bit expect_empty);
    while (obs_ptr < cam_obs.size()) begin
      if (cam_exp.size() == 0) begin
        chk({tag, "_cam_extra"}, 32'd1, 32'd0);
      end else begin
        chk({tag, "_cam_addr"}, cam_obs[obs_ptr], cam_exp.pop_front());
      end
      obs_ptr++;
    end
    if (expect_empty) chk({tag, "_cam_missing"}, cam_exp.size(), 0);
    cam_exp.delete();
  endtask

  task automatic wait_both_idle(input string tag);
    cyc = 0;
    while ((busy || busy_3) && cyc < 400) begin
      step();
      cyc++;
    end
    chk(tag, busy | busy_3, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int off, p;

    // Reset values while reset is held
    repeat (3) step();
    chk("rst_ready", start_ready, 0);
    chk("rst_cnt", MVU_counter, 8'hFF);
    chk("rst_busy", busy, 0);
    chk("rst_cam", cam_rd_en, 0);
    chk("rst_rv", round_valid, 0);
    chk("rst_pidx", pass_idx, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_ready3", start_ready_3, 0);
    reset = 1'b1;
    step();
    chk("rel_ready", start_ready, 1);

    // Single pass
    rvb = rv_cnt; db = done_cnt;
    push_reads(64);
    start_passes = 8'd1; start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    for (int i = 0; i < 68; i++) begin
      chk("t1_cnt", MVU_counter, i);
      chk("t1_cam_en", cam_rd_en, (i < 64));
      chk("t1_rv", round_valid, (i >= 5));
      chk("t1_ready", start_ready, 0);
      step();
    end
    chk("t1_done", done, 1);
    chk("t1_done_cnt", MVU_counter, 8'hFF);
    chk("t1_done_rv", round_valid, 1);
    step();
    chk("t1_done_off", done, 0);
    chk("t1_idle_cnt", MVU_counter, 8'hFF);
    chk("t1_ready_back", start_ready, 1);
    chk("t1_rv_total", rv_cnt - rvb, 64);
    chk("t1_done_pulses", done_cnt - db, 1);
    sb_drain("t1", 1'b1);

    // Three passes with gaps
    rvb = rv_cnt;
    push_reads(192);
    start_passes = 8'd3; start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    for (int c = 0; c < 208; c++) begin
      off = c % 70;
      p = c / 70;
      chk("t2_cnt", MVU_counter, (off < 68) ? off : 255);
      chk("t2_pidx", pass_idx, p);
      chk("t2_done_early", done, 0);
      step();
    end
    chk("t2_done", done, 1);
    step();
    chk("t2_pidx_hold", pass_idx, 2);
    chk("t2_rv_total", rv_cnt - rvb, 192);
    sb_drain("t2", 1'b1);

    // Zero passes
    rvb = rv_cnt;
    start_passes = 8'd0; start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    chk("t3_done", done, 1);
    chk("t3_cam", cam_rd_en, 0);
    chk("t3_rv", round_valid, 0);
    chk("t3_ready", start_ready, 0);
    chk("t3_busy", busy, 1);
    step();
    chk("t3_done_off", done, 0);
    chk("t3_ready_back", start_ready, 1);
    chk("t3_rv_total", rv_cnt - rvb, 0);
    sb_drain("t3", 1'b1);

    // Abort at counter 30 of pass 1
    rvb = rv_cnt; db = done_cnt; ab = abort_cnt;
    push_reads(95);
    start_passes = 8'd2; start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    repeat (100) step();
    chk("t4_cnt30", MVU_counter, 30);
    chk("t4_pidx", pass_idx, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_ab_cnt", MVU_counter, 8'hFF);
    chk("t4_aborted", aborted, 1);
    chk("t4_ab_rv", round_valid, 0);
    chk("t4_ab_done", done, 0);
    chk("t4_ab_busy", busy, 0);
    chk("t4_ab_ready", start_ready, 1);
    chk("t4_rv_total", rv_cnt - rvb, 90);
    sb_drain("t4", 1'b1);
    push_reads(64);
    start_passes = 8'd1; start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    chk("t4_new_cnt", MVU_counter, 0);
    chk("t4_aborted_off", aborted, 0);
    chk("t4_new_pidx", pass_idx, 0);
    repeat (68) step();
    chk("t4_new_done", done, 1);
    chk("t4_no_done_on_abort", done_cnt - db, 0);
    chk("t4_abort_pulses", abort_cnt - ab, 1);
    step();
    sb_drain("t4b", 1'b1);

    // start_valid held high: accept gated by DONE and pipeline drain
    wait_both_idle("t5_idle_wait");
    rvb3 = rv3_cnt;
    push_reads(128);
    start_passes = 8'd1; start_valid = 1'b1;
    step();
    for (int c = 0; c < 72; c++) begin
      chk("t5_rdy3", start_ready_3, (c >= 71));
      chk("t5_rv3", round_valid_3, (c >= 7 && c <= 70));
      chk("t5_done3", done_3, (c == 68));
      chk("t5_rdy1", start_ready, (c == 69));
      step();
    end
    chk("t5_cnt3", MVU_counter_3, 0);
    chk("t5_cnt1", MVU_counter, 2);
    chk("t5_rv3_total", rv3_cnt - rvb3, 64);
    start_valid = 1'b0;
    wait_both_idle("t5_drain_wait");
    sb_drain("t5", 1'b1);

    // Asynchronous reset mid-job
    push_reads(64);
    start_passes = 8'd1; start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    repeat (50) step();
    chk("t6_cnt50", MVU_counter, 50);
    db = done_cnt; ab = abort_cnt;
    #2 reset = 1'b0;
    #1;
    chk("t6_cnt", MVU_counter, 8'hFF);
    chk("t6_ready", start_ready, 0);
    chk("t6_busy", busy, 0);
    chk("t6_cam", cam_rd_en, 0);
    chk("t6_rv", round_valid, 0);
    chk("t6_pidx", pass_idx, 0);
    chk("t6_cnt3", MVU_counter_3, 8'hFF);
    sb_drain("t6", 1'b0);
    repeat (2) step();
    reset = 1'b1;
    step();
    chk("t6_rel_ready", start_ready, 1);
    chk("t6_rel_cnt", MVU_counter, 8'hFF);
    chk("t6_no_done", done_cnt - db, 0);
    chk("t6_no_abort", abort_cnt - ab, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mvu_sequencer.md
Name: mvu_sequencer

Overview:
- Control block that sequences the match-vector unit (MVU). It drives the MVU's 8-bit phase counter.
- It also generates the CAM read addresses for the find-max phase and flags valid rounded-output cycles.
- It accepts jobs over a valid/ready handshake. Each job runs 1-255 back-to-back passes separated by idle gap cycles.
- Sits between the top-level SASA controller and the MVU/CAM pair.

Parameters:
- FIND_LEN, 64, find-max cycles per pass (CAM rows read); MVU FindMax is active while counter bit 6 is 0.
- ROUND_START, 4, counter value at which the rounding window opens.
- ROUND_LEN, 64, rounding window length; RUN_LEN = ROUND_START + ROUND_LEN = 68.
- ROUND_LAT, 1, pipeline latency of the rounding datapath, in cycles (≥1).
- GAP_LEN, 2, idle cycles between passes (≥1).
- IDLE_CNT, 8'hFF, counter value driven when not running; bit 6 = 1 and value ≥ RUN_LEN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_valid  in  1  job request.
- start_ready  out  1  sequencer can accept a job.
- start_passes  in  8  number of passes; sampled on accept.
- abort  in  1  cancel the current job.
- MVU_counter  out  8  phase counter to the MVU.
- cam_rd_en  out  1  CAM read strobe.
- cam_rd_addr  out  6  CAM row address.
- round_valid  out  1  Round_data is valid this cycle.
- pass_idx  out  8  index of the current pass, 0-based.
- busy  out  1  job or rounding pipeline active.
- done  out  1  one-cycle pulse at normal completion.
- aborted  out  1  one-cycle pulse on abort.

Behaviour:
- States: IDLE, RUN, GAP, DONE. All state, counters and outputs are registered, except the combinational decodes listed below.
- Reset (reset=0, asynchronous) values:
  - state=IDLE, MVU_counter=IDLE_CNT.
  - pass_idx=0, passes register=0.
  - gap counter=0, round pipeline=0.
  - done=0, aborted=0, cam_rd_en=0, round_valid=0, busy=0.
  - start_ready=0 while reset is held; 1 from the first cycle after reset release.
- start_ready = (state==IDLE) && (round pipeline empty).
- Accept: start_valid && start_ready at a clock edge; latch start_passes.
  - passes≥1: next state RUN, MVU_counter=0, pass_idx=0.
  - passes==0: next state DONE, no RUN cycles, no CAM reads.
- RUN:
  - MVU_counter increments by 1 each cycle from 0 to RUN_LEN-1 (67).
  - At 67 with pass_idx==passes-1: go to DONE.
  - At 67 otherwise: go to GAP.
- GAP:
  - MVU_counter=IDLE_CNT for exactly GAP_LEN cycles.
  - Then RUN with MVU_counter=0 and pass_idx+1. pass_idx updates on GAP→RUN.
- DONE: exactly one cycle; done=1, MVU_counter=IDLE_CNT; then IDLE. pass_idx holds its last value until the next accept.
- cam_rd_en = (state==RUN) && (MVU_counter<FIND_LEN); combinational from registered state.
- cam_rd_addr = MVU_counter[5:0] when cam_rd_en=1, else 0.
- round window = (state==RUN) && (ROUND_START ≤ MVU_counter ≤ RUN_LEN-1). It is delayed ROUND_LAT cycles through a shift register to give round_valid.
  - round_valid may trail into GAP/DONE/IDLE by up to ROUND_LAT cycles.
  - Exactly ROUND_LEN round_valid cycles per pass.
- busy = (state!=IDLE) || (round pipeline nonzero).
- abort:
  - Sampled in RUN or GAP: next cycle state=IDLE, MVU_counter=IDLE_CNT, round pipeline cleared, aborted=1 for one cycle, done not asserted.
  - Ignored in IDLE and DONE.
  - In IDLE, start and abort in the same cycle: the job is accepted and abort is ignored.
- Counter never wraps: MVU_counter leaves RUN at 67. IDLE_CNT is never reached by incrementing.
- Reset asserted mid-job: all registers return to reset values immediately. No done or aborted pulse.

Test Plan:
- Reset, then start_passes=1:
  - MVU_counter runs 0..67 over 68 cycles.
  - cam_rd_en high exactly 64 cycles with addr 0..63.
  - round_valid high 64 cycles, starting ROUND_LAT cycles after counter=4.
  - done pulses once; MVU_counter=8'hFF afterward.
- start_passes=3, GAP_LEN=2: three 68-cycle RUNs, each separated by 2 cycles of MVU_counter=8'hFF. pass_idx goes 0,1,2. Total 68*3+2*2 = 208 cycles before DONE.
- start_passes=0: done pulses the cycle after accept. cam_rd_en and round_valid never assert. start_ready returns to 1 the following cycle.
- abort at MVU_counter=30 of pass 1 (passes=2):
  - Next cycle MVU_counter=8'hFF, aborted=1, round_valid=0, done never asserts.
  - A new job is accepted 1 cycle later.
- start_valid held high continuously with passes=1: second accept occurs only after DONE and after the round pipeline drains (ROUND_LAT=3 check). start_ready stays 0 throughout RUN.
- reset driven low at MVU_counter=50: all outputs drop to reset values asynchronously before the next edge. After release, start_ready=1 and no done pulse.
